// File: rtl/kbd_tone_pkg.sv
// Shared definitions for the keyboard tone synth: envelope states, limits and
// the note-to-phase-increment table builder.
package kbd_tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_e;

    localparam int          NOTE_MAX = 36;
    localparam logic [15:0] ENV_MAX  = 16'hFFFF;

    localparam real C4_HZ    = 261.6255653005986;
    localparam real SEMITONE = 1.0594630943592953;

    typedef logic [NOTE_MAX-1:0][31:0] inc_tab_t;

    // Elaboration-time only: entry i is round(f(C4 + i semitones) * 2^phase_w / sample_hz).
    function automatic inc_tab_t inc_table(input int sample_hz, input int phase_w);
        inc_tab_t t;
        real      f;
        real      scale;
        t     = '0;
        scale = 1.0;
        for (int i = 0; i < phase_w; i++) scale = scale * 2.0;
        f = C4_HZ;
        for (int i = 0; i < NOTE_MAX; i++) begin
            t[i] = 32'($rtoi(f * scale / $itor(sample_hz) + 0.5));
            f    = f * SEMITONE;
        end
        return t;
    endfunction

endpackage

// File: rtl/kbd_tone_synth_envelope.sv
// Attack/sustain/release envelope FSM, advanced once per sample tick.
module tone_envelope
    import kbd_tone_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP  = 16'h0100,
    parameter logic [15:0] RELEASE_STEP = 16'h0040
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_tick,
    input  logic        i_note_valid,
    output logic [15:0] o_env,
    output logic [1:0]  o_state
);

    env_state_e  r_state;
    logic [15:0] r_env;

    logic [16:0] w_up_sum;
    logic        w_up_sat;
    logic [15:0] w_up_env;
    logic        w_dn_zero;
    logic [15:0] w_dn_env;

    assign w_up_sum  = {1'b0, r_env} + {1'b0, ATTACK_STEP};
    assign w_up_sat  = w_up_sum >= {1'b0, ENV_MAX};
    assign w_up_env  = w_up_sat ? ENV_MAX : w_up_sum[15:0];
    assign w_dn_zero = r_env <= RELEASE_STEP;
    assign w_dn_env  = w_dn_zero ? 16'd0 : r_env - RELEASE_STEP;

    // A held note always ramps up; a saturated ramp is exactly sustain, so
    // re-keying in SUSTAIN stays there and re-keying in RELEASE resumes attack.
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state <= ST_IDLE;
            r_env   <= 16'd0;
        end else if (i_tick) begin
            if (i_note_valid) begin
                r_env   <= w_up_env;
                r_state <= w_up_sat ? ST_SUSTAIN : ST_ATTACK;
            end else if (r_state != ST_IDLE) begin
                r_env   <= w_dn_env;
                r_state <= w_dn_zero ? ST_IDLE : ST_RELEASE;
            end else begin
                r_env   <= 16'd0;
            end
        end
    end

    assign o_env   = r_env;
    assign o_state = r_state;

endmodule

// File: rtl/kbd_tone_synth.sv
// Note code -> DDS tone with ASR envelope, one signed PCM sample per tick.
// Define KBD_TONE_TRIANGLE_EN for a triangle wave instead of a square.
module kbd_tone_synth
    import kbd_tone_pkg::*;
#(
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          SAMPLE_HZ    = 48_000,
    parameter int          PHASE_W      = 24,
    parameter logic [15:0] ATTACK_STEP  = 16'h0100,
    parameter logic [15:0] RELEASE_STEP = 16'h0040
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [7:0]  key_8,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        active,
    output logic [15:0] env_level
);

    localparam int       DIV     = CLK_HZ / SAMPLE_HZ;
    localparam int       CNT_W   = $clog2(DIV);
    localparam inc_tab_t INC_TAB = inc_table(SAMPLE_HZ, PHASE_W);

    logic [CNT_W-1:0]   r_cnt;
    logic               w_tick;
    logic               w_note_valid;
    logic [5:0]         w_idx;
    logic [PHASE_W-1:0] w_tab_inc;
    logic [PHASE_W-1:0] w_inc_now;
    logic [PHASE_W-1:0] r_inc;
    logic [PHASE_W-1:0] r_phase;
    logic [15:0]        w_env;
    logic [1:0]         w_state_raw;
    env_state_e         w_state;
    logic signed [15:0] w_wave;
    logic signed [31:0] w_prod;
    logic [1:0]         r_vld_pipe;
    logic [15:0]        r_sample;
    logic               r_active;

    assign w_tick = r_cnt == CNT_W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (clrn || w_tick) r_cnt <= '0;
        else                r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_note_valid = (key_8 != 8'd0) && (key_8 <= 8'(NOTE_MAX));
    assign w_idx        = key_8[5:0] - 6'd1;
    assign w_tab_inc    = INC_TAB[w_idx][PHASE_W-1:0];
    // A new valid code takes effect on the very tick it is sampled.
    assign w_inc_now    = w_note_valid ? w_tab_inc : r_inc;

    tone_envelope #(
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
        .clk          (clk),
        .clrn         (clrn),
        .i_tick       (w_tick),
        .i_note_valid (w_note_valid),
        .o_env        (w_env),
        .o_state      (w_state_raw)
    );

    assign w_state = env_state_e'(w_state_raw);

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_inc   <= '0;
            r_phase <= '0;
        end else begin
            if (w_tick && w_note_valid) r_inc <= w_tab_inc;
            // Held at zero while idle, so every note starts from phase 0.
            if (w_state == ST_IDLE) r_phase <= '0;
            else if (w_tick)        r_phase <= r_phase + w_inc_now;
        end
    end

`ifdef KBD_TONE_TRIANGLE_EN
    logic [16:0] w_top;
    logic [15:0] w_ramp;
    assign w_top  = r_phase[PHASE_W-1 -: 17];
    assign w_ramp = {1'b0, w_top[14:0]};
    always_comb begin
        w_wave = 16'sd0;
        case (w_top[16:15])
            2'd0: w_wave = $signed(w_ramp);
            2'd1: w_wave = 16'sd32767 - $signed(w_ramp);
            2'd2: w_wave = -$signed(w_ramp);
            2'd3: w_wave = $signed(w_ramp) - 16'sd32767;
            default: w_wave = 16'sd0;
        endcase
    end
`else
    assign w_wave = r_phase[PHASE_W-1] ? -16'sd32767 : 16'sd32767;
`endif

    assign w_prod = 32'(w_wave) * 32'($signed({1'b0, w_env}));

    // Stage 0 marks the tick, stage 1 is the output strobe one cycle later.
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_vld_pipe <= 2'b00;
            r_sample   <= 16'd0;
            r_active   <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_tick};
            if (r_vld_pipe[0]) begin
                r_active <= w_state != ST_IDLE;
                r_sample <= (w_state == ST_IDLE) ? 16'd0 : 16'(w_prod >>> 16);
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_vld_pipe[1];
    assign active       = r_active;
    assign env_level    = w_env;

endmodule

// File: tb/tb_kbd_tone_synth.sv
// Scoreboard bench for kbd_tone_synth: a per-tick note/envelope model pushes
// expected samples, a negedge monitor pops them on sample_valid.
module tb_kbd_tone_synth;

    localparam int SAMPLE_HZ = 48_000;
    localparam int DIV       = 16;
    localparam int CLK_HZ    = SAMPLE_HZ * DIV;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic [7:0]  key_8 = 8'd10;
    logic [15:0] sample;
    logic        sample_valid;
    logic        active;
    logic [15:0] env_level;

    int checks = 0;
    int errors = 0;

    kbd_tone_synth #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .key_8        (key_8),
        .sample       (sample),
        .sample_valid (sample_valid),
        .active       (active),
        .env_level    (env_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int smp;
        bit act;
        int env;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Equal-tempered pitch relative to A4 = code 10.
    function automatic longint inc_of(input int k);
        real f;
        f = 440.0 * $pow(2.0, $itor(k - 10) / 12.0);
        return longint'($rtoi(f * 16777216.0 / $itor(SAMPLE_HZ) + 0.5));
    endfunction

    // Reference model: note sounding flag, envelope level and phase as plain numbers.
    int     m_cnt = 0;
    bit     m_sounding = 0;
    int     m_env = 0;
    longint m_phase = 0;
    longint m_inc = 0;
    bit     m_pend = 0;
    bit     m_exp_vld = 0;

    initial forever begin
        @(posedge clk);
        if (clrn) begin
            m_cnt = 0; m_sounding = 0; m_env = 0; m_phase = 0; m_inc = 0;
            m_pend = 0; m_exp_vld = 0;
            q.delete();
        end else begin
            m_exp_vld = m_pend;
            m_pend    = 0;
            if (m_cnt == DIV - 1) begin
                int   k;
                exp_t e;
                m_cnt = 0;
                k = int'(key_8);
                if (k >= 1 && k <= 36) begin
                    m_inc = inc_of(k);
                    if (!m_sounding) begin
                        m_sounding = 1;
                        m_phase    = 0;
                    end else begin
                        m_phase = (m_phase + m_inc) % 64'd16777216;
                    end
                    m_env = (m_env + 256 > 65535) ? 65535 : m_env + 256;
                end else if (m_sounding) begin
                    m_phase = (m_phase + m_inc) % 64'd16777216;
                    m_env   = (m_env - 64 < 0) ? 0 : m_env - 64;
                    if (m_env == 0) begin
                        m_sounding = 0;
                        m_phase    = 0;
                    end
                end
                e.act = m_sounding;
                e.env = m_env;
                if (!m_sounding) e.smp = 0;
                else e.smp = ((m_phase >= 64'd8388608) ? -32767 : 32767) * m_env >>> 16;
                q.push_back(e);
                m_pend = 1;
            end else begin
                m_cnt++;
            end
        end
    end

    bit mon_en = 0;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("valid_timing", longint'(sample_valid), longint'(m_exp_vld));
            if (sample_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got sample_valid with no expected entry at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_sample", longint'($signed(sample)), longint'(e.smp));
                    chk("sb_active", longint'(active), longint'(e.act));
                    chk("sb_env",    longint'(env_level), longint'(e.env));
                end
            end
        end
    end

    task automatic wait_samples(input int n);
        for (int i = 0; i < n; i++) begin
            int b;
            b = 0;
            @(negedge clk);
            while (!sample_valid && b < 4 * DIV) begin
                @(negedge clk);
                b++;
            end
            if (!sample_valid) begin
                checks++; errors++;
                $display("FAIL sample_timeout: got no sample_valid expected one within %0d cycles", 4 * DIV);
            end
        end
    endtask

    // Called right after a sample strobe, so the pulse stays clear of the next tick.
    task automatic glitch(input logic [7:0] v);
        logic [7:0] keep;
        keep = key_8;
        repeat (2) @(negedge clk);
        key_8 = v;
        repeat (DIV / 2) @(negedge clk);
        key_8 = keep;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_sample"}, longint'(sample), 0);
        chk({nm, "_valid"},  longint'(sample_valid), 0);
        chk({nm, "_active"}, longint'(active), 0);
        chk({nm, "_env"},    longint'(env_level), 0);
    endtask

    initial begin
        clrn  = 1'b1;
        key_8 = 8'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mon_en = 1;
            chk_zero("reset");
        end
        clrn = 1'b0;

        // A4 attack to saturation, then sustain
        wait_samples(255);
        chk("attack_255", longint'(env_level), 65280);
        wait_samples(1);
        chk("attack_sat", longint'(env_level), 65535);
        wait_samples(20);

        // legato retune keeps envelope and phase running
        key_8 = 8'd13;
        wait_samples(10);
        chk("retune_env", longint'(env_level), 65535);
        chk("retune_active", longint'(active), 1);

        // partial release then retrigger from the current level
        key_8 = 8'd0;
        wait_samples(100);
        chk("release_100", longint'(env_level), 59135);
        key_8 = 8'd1;
        wait_samples(24);
        chk("retrig_24", longint'(env_level), 65279);
        wait_samples(1);
        chk("retrig_25", longint'(env_level), 65535);
        wait_samples(10);

        // full release to idle
        key_8 = 8'd0;
        wait_samples(1023);
        chk("release_1023_env", longint'(env_level), 63);
        chk("release_1023_act", longint'(active), 1);
        wait_samples(1);
        chk("release_done_env", longint'(env_level), 0);
        chk("release_done_act", longint'(active), 0);
        wait_samples(5);
        chk("idle_sample", longint'(sample), 0);

        // out-of-range codes and a sub-tick glitch leave the synth idle
        key_8 = 8'd37;
        wait_samples(5);
        key_8 = 8'hF0;
        wait_samples(5);
        chk("invalid_active", longint'(active), 0);
        key_8 = 8'd0;
        wait_samples(1);
        glitch(8'd10);
        wait_samples(3);
        chk("glitch_active", longint'(active), 0);
        chk("glitch_sample", longint'(sample), 0);

        // randomized key sequences with glitches and one mid-note reset
        for (int s = 0; s < 40; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)      key_8 = 8'd0;
            else if (r < 8) key_8 = 8'($urandom_range(1, 36));
            else            key_8 = 8'($urandom_range(37, 255));
            wait_samples(1);
            if ($urandom_range(0, 3) == 0) glitch(8'($urandom_range(0, 255)));
            wait_samples(int'($urandom_range(1, 30)));
            if (s == 20) begin
                key_8 = 8'd22;
                wait_samples(40);
                clrn = 1'b1;
                @(negedge clk);
                chk_zero("midreset");
                @(negedge clk);
                clrn = 1'b0;
            end
        end

        key_8 = 8'd0;
        repeat (3) @(negedge clk);
        chk("queue_drained", longint'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
